// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU into HI/LO,
// plus MFHI/MFLO/MTHI/MTLO access and the busy flag the D-stage stall logic uses.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_Req,
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_MDUOut
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] shi_q, shi_d, slo_q, slo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic        idle_ok, is_md, is_sdiv;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    assign idle_ok = !E_Req && !busy_q;
    assign is_md   = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);
    assign E_Start = is_md && idle_ok;
    assign E_Busy  = busy_q;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    assign prod_u = {32'd0, E_A} * {32'd0, E_B};

    // One unsigned divider serves both forms; signed ops divide magnitudes and
    // fix signs afterwards, which also yields 0x80000000 / -1 = 0x80000000 r 0.
    assign is_sdiv = (E_MDUOp == OP_DIV);
    assign a_mag   = (is_sdiv && E_A[31]) ? -E_A : E_A;
    assign b_mag   = (is_sdiv && E_B[31]) ? -E_B : E_B;
    assign q_mag   = (b_mag != 32'd0) ? a_mag / b_mag : 32'd0;
    assign r_mag   = (b_mag != 32'd0) ? a_mag % b_mag : 32'd0;
    assign quo     = (is_sdiv && (E_A[31] ^ E_B[31])) ? -q_mag : q_mag;
    assign rem     = (is_sdiv && E_A[31]) ? -r_mag : r_mag;

    always_comb begin
        E_MDUOut = 32'd0;
        if (E_MDUOp == OP_MFHI)      E_MDUOut = hi_q;
        else if (E_MDUOp == OP_MFLO) E_MDUOut = lo_q;
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        shi_d  = shi_q;
        slo_d  = slo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                hi_d   = shi_q;
                lo_d   = slo_q;
            end
        end else if (E_Start) begin
            busy_d = 1'b1;
            unique case (E_MDUOp)
                OP_MULT:  begin {shi_d, slo_d} = prod_s; cnt_d = 4'(MULT_CYCLES); end
                OP_MULTU: begin {shi_d, slo_d} = prod_u; cnt_d = 4'(MULT_CYCLES); end
                default: begin
                    cnt_d = 4'(DIV_CYCLES);
                    // Divide by zero commits the current HI/LO, i.e. leaves them as-is.
                    if (E_B == 32'd0) begin
                        shi_d = hi_q;
                        slo_d = lo_q;
                    end else begin
                        shi_d = rem;
                        slo_d = quo;
                    end
                end
            endcase
        end else if (idle_ok) begin
            if (E_MDUOp == OP_MTHI)      hi_d = E_A;
            else if (E_MDUOp == OP_MTLO) lo_d = E_A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            shi_q  <= 32'd0;
            slo_q  <= 32'd0;
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            shi_q  <= shi_d;
            slo_q  <= slo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO results, busy timing, E_Req
// suppression, reset mid-operation and back-to-back acceptance.
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDUOp;
    logic [31:0] E_A, E_B;
    logic        E_Req;
    logic        E_Start, E_Busy;
    logic [31:0] E_MDUOut;

    int checks = 0;
    int failures = 0;

    e_mdu dut (
        .clk(clk), .reset(reset), .E_MDUOp(E_MDUOp), .E_A(E_A), .E_B(E_B),
        .E_Req(E_Req), .E_Start(E_Start), .E_Busy(E_Busy), .E_MDUOut(E_MDUOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        logic [3:0] sv_op;
        sv_op = E_MDUOp;
        E_MDUOp = 4'd5; #1;
        chk({tag, ".hi"}, E_MDUOut, ehi);
        E_MDUOp = 4'd6; #1;
        chk({tag, ".lo"}, E_MDUOut, elo);
        E_MDUOp = sv_op; #1;
    endtask

    // Counts busy cycles starting from the cycle after the accept.
    task automatic wait_idle(output int n);
        n = 0;
        while (E_Busy && n < 40) begin
            n++;
            cyc();
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int ncyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        E_MDUOp = op; E_A = a; E_B = b; E_Req = 1'b0; #1;
        chk({tag, ".start"}, 32'(E_Start), 32'd1);
        cyc();
        E_MDUOp = 4'd0;
        wait_idle(n);
        chk({tag, ".busycyc"}, 32'(n), 32'(ncyc));
        read_hilo(tag, ehi, elo);
    endtask

    initial begin
        int n;
        reset = 1'b1; E_MDUOp = 4'd0; E_A = '0; E_B = '0; E_Req = 1'b0;
        cyc(); cyc();
        reset = 1'b0; #1;
        chk("rst.busy", 32'(E_Busy), 32'd0);
        read_hilo("rst", 32'h0, 32'h0);
        E_MDUOp = 4'd0; #1;
        chk("rst.out_none", E_MDUOut, 32'h0);

        run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        cyc();
        E_MDUOp = 4'd5; #1;
        chk("mult.mfhi_late", E_MDUOut, 32'hFFFFFFFF);
        E_MDUOp = 4'd0;

        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
        run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("divneg", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

        // E_Req suppresses MTHI and a concurrent MULT's acceptance.
        E_MDUOp = 4'd7; E_A = 32'h12345678; E_Req = 1'b1;
        cyc();
        read_hilo("mthi_req", 32'd1, 32'hFFFFFFFD);
        E_MDUOp = 4'd1; E_A = 32'd5; E_B = 32'd5; #1;
        chk("req.start", 32'(E_Start), 32'd0);
        cyc();
        chk("req.busy", 32'(E_Busy), 32'd0);
        E_MDUOp = 4'd7; E_A = 32'h12345678; E_Req = 1'b0;
        cyc();
        E_MDUOp = 4'd0; #1;
        read_hilo("mthi", 32'h12345678, 32'hFFFFFFFD);
        E_MDUOp = 4'd8; E_A = 32'hCAFEF00D;
        cyc();
        read_hilo("mtlo", 32'h12345678, 32'hCAFEF00D);

        // Reset during busy cycle 3 of a DIV discards it.
        E_MDUOp = 4'd3; E_A = 32'd100; E_B = 32'd7; #1;
        cyc();
        E_MDUOp = 4'd0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; #1;
        chk("rstmid.busy", 32'(E_Busy), 32'd0);
        read_hilo("rstmid", 32'h0, 32'h0);
        for (int i = 0; i < 12; i++) cyc();
        read_hilo("rstmid.late", 32'h0, 32'h0);

        // MULT issued while busy is ignored.
        E_MDUOp = 4'd1; E_A = 32'd6; E_B = 32'd7; #1;
        cyc();
        cyc();
        E_MDUOp = 4'd1; E_A = 32'd100; E_B = 32'd100; #1;
        chk("busyign.start", 32'(E_Start), 32'd0);
        cyc();
        E_MDUOp = 4'd0;
        wait_idle(n);
        chk("busyign.rem", 32'(n), 32'd3);
        read_hilo("busyign", 32'h0, 32'd42);

        // Back-to-back MULTs: the held op re-accepts exactly 6 cycles later.
        E_MDUOp = 4'd1; E_A = 32'hFFFFFFFF; E_B = 32'd9; #1;
        chk("b2b.start1", 32'(E_Start), 32'd1);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!E_Start && n < 20);
        chk("b2b.gap", 32'(n), 32'd6);
        read_hilo("b2b.first", 32'hFFFFFFFF, 32'hFFFFFFF7);
        E_MDUOp = 4'd1; E_A = 32'd3; E_B = 32'd4; #1;
        cyc();
        E_MDUOp = 4'd0;
        wait_idle(n);
        chk("b2b.busy2", 32'(n), 32'd5);
        read_hilo("b2b.second", 32'h0, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
# e_mdu

Multi-cycle multiply/divide unit in the E stage of the five-stage MIPS pipeline. It accepts operands forwarded into E from the D-stage register reads and runs MULT/MULTU/DIV/DIVU over a fixed latency. Results go to HI/LO, which MFHI/MFLO read back and MTHI/MTLO write. It drives the busy indication that the D-stage stall logic consumes.

## Interface
- MULT_CYCLES, 5: busy cycles for MULT/MULTU.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU.
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- E_MDUOp  in  4  operation code:
  - 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
  - 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
  - 9–15 treated as none.
- E_A  in  32  rs operand (forwarded).
- E_B  in  32  rt operand (forwarded).
- E_Req  in  1  exception/interrupt commit this cycle; suppresses all state changes requested by the E instruction.
- E_Start  out  1  combinational; an op 1–4 is accepted this cycle.
- E_Busy  out  1  registered; an operation is in flight.
- E_MDUOut  out  32  combinational; HI for MFHI, LO for MFLO, 0 otherwise.

## Operation
- State: HI, LO (32 b each), cnt (4 b), busy flag, pending HI/LO shadow registers.
- Accept condition: E_MDUOp ∈ {1..4}, E_Req=0, busy=0. E_Start mirrors this condition.
- On accept:
  - Compute the result into the shadow registers.
  - Load cnt with MULT_CYCLES or DIV_CYCLES and set busy.
- Op 1–4 with busy=1: ignored. The stall unit guarantees this does not occur; it must not corrupt state.
- Busy: cnt decrements each cycle. In the cycle where cnt=1, at the clock edge:
  - busy clears.
  - Shadow registers commit to HI/LO.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
- DIV:
  - LO = quotient, truncated toward zero.
  - HI = remainder, same sign as the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: the operation still occupies DIV_CYCLES; HI/LO are left unchanged at commit.
- MTHI/MTLO: write E_A to HI/LO at the clock edge when E_Req=0 and busy=0. If busy=1 they are ignored (stall-unit guarantee).
- MFHI/MFLO: read the current HI/LO combinationally. Pending shadow values are not bypassed.
- E_Req=1 does not abort an operation already in flight; that operation belongs to an older, committed instruction.
- Reset:
  - HI=0, LO=0, cnt=0, busy=0, shadow=0.
  - Reset mid-operation discards the operation with no commit.
- Outputs after reset: E_Busy=0. E_Start and E_MDUOut follow the inputs; E_MDUOut reads 0 for MFHI/MFLO.

## Timing
- Accept in cycle T (E_Start=1) → E_Busy=1 in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO hold new values from cycle T+N+1. E_Busy=0 in T+N+1.
- A new op may be accepted in T+N+1, giving back-to-back throughput of N+1 cycles.
- MFHI issued in T+N+1 returns the new value. Stall logic holds an MD instruction in D while E_Start | E_Busy.
- MTHI/MTLO in cycle T → visible to MFHI/MFLO in T+1.
- Simultaneous commit and MTHI/MTLO cannot occur, because busy blocks MT*.
- cnt never wraps; it stays at 0 while idle.

## Test plan
- MULT 0xFFFFFFFE × 3 (-2×3):
  - E_Busy high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MFHI one cycle later returns 0xFFFFFFFF.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles.
  - DIVU 7/0: 10 busy cycles, HI/LO unchanged.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x12345678 with E_Req=1:
  - HI unchanged, E_Start=0 for a concurrent MULT.
  - Repeat with E_Req=0: HI=0x12345678 the next cycle.
- Reset asserted in busy cycle 3 of a DIV:
  - Next cycle E_Busy=0 and HI=LO=0.
  - No later commit occurs.
- MULT issued while busy is ignored: the original result commits on schedule.
- Back-to-back MULT, MULT: the second is accepted exactly 6 cycles after the first.
